adat_sync_rx: RTL and testbench

Synchronous ADAT lightpipe deframer clocked on the ADAT bit clock (~12.288 MHz). It decodes an NRZI ADAT bitstream that shares the receiver's clock, such as the mixer's own `adat_out` looped back or a clock-slaved device. It recovers eight signed 24-bit channels plus user bits. It serves as the loopback checker for the transmit path and as the input stage wherever no oversampling receiver is needed.

---
 rtl/adat_sync_rx.sv | 162 ++++++++++++++++
 tb/tb_adat_sync_rx.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adat_sync_rx.sv
// adat_sync_rx: synchronous ADAT lightpipe deframer clocked on the ADAT bit clock.
// Decodes the NRZI line and checks framing (sync, 49 separators). On each good
// frame it publishes eight signed 24-bit channels and the user nibble.
// Optional feature: define ADAT_SYNC_RX_ERR_COUNT_EN to add a saturating
// 16-bit framing-error counter on port err_count.
`timescale 1ns/1ps

module adat_sync_rx (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     adat_bitstream,
    output logic signed [23:0]       audio_bus [0:7],
    output logic        [3:0]        user_bits,
    output logic                     data_valid,
    output logic                     locked,
    output logic                     frame_error
`ifdef ADAT_SYNC_RX_ERR_COUNT_EN
    ,
    output logic        [15:0]       err_count
`endif
);

    typedef enum logic [1:0] {HUNT, USER, DATA, SYNC} state_t;

    state_t         state;
    state_t         state_nxt;
    logic           s0;
    logic           b;
    logic [3:0]     zrun;
    logic [2:0]     phase;
    logic [7:0]     bit_cnt;
    logic [3:0]     user_shift;
    logic [191:0]   staging;
    logic           sep_slot;
    logic           frame_good;
    logic           frame_bad;

    // A level change between consecutive samples is a logical 1, so the line
    // polarity never matters.
    assign b        = adat_bitstream ^ s0;
    // Every fifth bit of the user field and of each data nibble is a separator.
    assign sep_slot = (phase == 3'd4);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: sync acquisition, field sequencing and violation exits
    always_comb begin
        state_nxt = state;
        case (state)
            HUNT: begin
                if (b && (zrun >= 4'd10)) state_nxt = USER;
            end
            USER: begin
                if (sep_slot) state_nxt = b ? DATA : HUNT;
            end
            DATA: begin
                if (sep_slot) begin
                    if (!b)                       state_nxt = HUNT;
                    else if (bit_cnt == 8'd239)   state_nxt = SYNC;
                end
            end
            SYNC: begin
                if (b)                    state_nxt = (zrun == 4'd10) ? USER : HUNT;
                else if (zrun == 4'd10)   state_nxt = HUNT;
            end
            default: state_nxt = HUNT;
        endcase
    end

    // Output decode: good-frame and framing-violation strobes for this bit
    always_comb begin
        frame_good = 1'b0;
        frame_bad  = 1'b0;
        case (state)
            USER: begin
                frame_bad = sep_slot && !b;
            end
            DATA: begin
                frame_bad  = sep_slot && !b;
                frame_good = sep_slot && b && (bit_cnt == 8'd239);
            end
            SYNC: begin
                // Exactly ten zeros then a one; an early one or an eleventh zero fails.
                frame_bad = b ? (zrun != 4'd10) : (zrun == 4'd10);
            end
            default: begin
                frame_bad  = 1'b0;
                frame_good = 1'b0;
            end
        endcase
    end

    // Line history, zero-run, bit-position counters and field shifters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0         <= 1'b0;
            zrun       <= '0;
            phase      <= '0;
            bit_cnt    <= '0;
            user_shift <= '0;
            staging    <= '0;
        end else begin
            s0      <= adat_bitstream;
            zrun    <= b ? 4'd0 : ((zrun == 4'd15) ? zrun : zrun + 4'd1);
            phase   <= (((state == USER) || (state == DATA)) && !sep_slot) ? phase + 3'd1 : 3'd0;
            bit_cnt <= (state == DATA) ? bit_cnt + 8'd1 : 8'd0;
            if ((state == USER) && !sep_slot) begin
                user_shift <= {user_shift[2:0], b};
            end
            if (frame_bad) begin
                staging <= '0;
            end else if ((state == DATA) && !sep_slot) begin
                staging <= {staging[190:0], b};
            end
        end
    end

    // Published outputs: channels and user nibble change only on a good frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 8; i++) begin
                audio_bus[i] <= '0;
            end
            user_bits   <= '0;
            data_valid  <= 1'b0;
            frame_error <= 1'b0;
            locked      <= 1'b0;
        end else begin
            data_valid  <= frame_good;
            frame_error <= frame_bad;
            if (frame_good) begin
                // Channel 0 arrived first, so it sits in the top of the staging word.
                for (int unsigned i = 0; i < 8; i++) begin
                    audio_bus[i] <= staging[(7 - i) * 24 +: 24];
                end
                user_bits <= user_shift;
                locked    <= 1'b1;
            end else if (frame_bad) begin
                locked <= 1'b0;
            end
        end
    end

`ifdef ADAT_SYNC_RX_ERR_COUNT_EN
    // Saturating count of framing violations; only reset clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (frame_bad && (err_count != 16'hFFFF)) begin
            err_count <= err_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_adat_sync_rx.sv
// tb_adat_sync_rx: self-checking bench for adat_sync_rx.
// A frame-level reference model turns frame descriptors (payload, sync length,
// corrupted separator) into a logical bit stream plus the expected output
// signature after every bit.
`timescale 1ns/1ps

module tb_adat_sync_rx;

    localparam int SIGW = 215;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               adat_bitstream = 1'b0;
    logic signed [23:0] audio_bus [0:7];
    logic [3:0]         user_bits;
    logic               data_valid;
    logic               locked;
    logic               frame_error;
`ifdef ADAT_SYNC_RX_ERR_COUNT_EN
    logic [15:0]        err_count;
`endif

    always #5 clk = ~clk;

    adat_sync_rx dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .adat_bitstream (adat_bitstream),
        .audio_bus      (audio_bus),
        .user_bits      (user_bits),
        .data_valid     (data_valid),
        .locked         (locked),
        .frame_error    (frame_error)
`ifdef ADAT_SYNC_RX_ERR_COUNT_EN
        ,
        .err_count      (err_count)
`endif
    );

    typedef struct {
        logic [3:0]        user;
        logic [7:0][23:0]  ch;
        int                sync_zeros;
        int                bad_sep;     // -1: none; 0: user separator; 1+6*ch+nibble
    } frame_t;

    typedef struct {
        bit              b;
        logic [SIGW-1:0] sig;
    } step_t;

    step_t           stim[$];
    logic [SIGW-1:0] obs[$];
    bit              fb[$];

    // Reference model state
    bit              m_hunting;
    int              m_zeros;
    logic [3:0]      m_user;
    logic [191:0]    m_ch;
    bit              m_locked;
    int              m_errs;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [191:0] flatten(input logic [7:0][23:0] ch);
        logic [191:0] r;
        r = '0;
        for (int c = 0; c < 8; c++) r[191 - 24 * c -: 24] = ch[c];
        return r;
    endfunction

    function automatic logic [SIGW-1:0] observe();
        logic [15:0] ec;
        ec = '0;
`ifdef ADAT_SYNC_RX_ERR_COUNT_EN
        ec = err_count;
`endif
        return {data_valid, frame_error, locked, user_bits,
                audio_bus[0], audio_bus[1], audio_bus[2], audio_bus[3],
                audio_bus[4], audio_bus[5], audio_bus[6], audio_bus[7], ec};
    endfunction

    function automatic frame_t rand_frame();
        frame_t f;
        f.user = 4'($urandom);
        for (int c = 0; c < 8; c++) f.ch[c] = 24'($urandom);
        f.sync_zeros = 10;
        f.bad_sep    = -1;
        return f;
    endfunction

    function automatic frame_t spec_frame();
        frame_t f;
        f.user  = 4'hA;
        f.ch[0] = 24'h000001; f.ch[1] = 24'h123456; f.ch[2] = 24'h7FFFFF; f.ch[3] = 24'h800000;
        f.ch[4] = 24'hFFFFFF; f.ch[5] = 24'h00F00F; f.ch[6] = 24'h555555; f.ch[7] = 24'hAAAAAA;
        f.sync_zeros = 10;
        f.bad_sep    = -1;
        return f;
    endfunction

    // Logical bits of one frame, MSB first, separators possibly corrupted.
    task automatic gen_bits(input frame_t f);
        fb.delete();
        repeat (f.sync_zeros) fb.push_back(1'b0);
        fb.push_back(1'b1);
        for (int k = 3; k >= 0; k--) fb.push_back(f.user[k]);
        fb.push_back(f.bad_sep != 0);
        for (int c = 0; c < 8; c++) begin
            for (int n = 0; n < 6; n++) begin
                for (int k = 0; k < 4; k++) fb.push_back(f.ch[c][23 - 4 * n - k]);
                fb.push_back(f.bad_sep != (1 + 6 * c + n));
            end
        end
    endtask

    task automatic model_reset();
        m_hunting = 1'b1;
        m_zeros   = 0;
        m_user    = '0;
        m_ch      = '0;
        m_locked  = 1'b0;
        m_errs    = 0;
    endtask

    task automatic push(input bit b, input bit dv, input bit fe,
                        input logic [3:0] u, input logic [191:0] ch);
        step_t s;
        logic [15:0] ec;
        if (dv) begin m_user = u; m_ch = ch; m_locked = 1'b1; end
        if (fe) begin m_locked = 1'b0; m_errs++; end
        ec = '0;
`ifdef ADAT_SYNC_RX_ERR_COUNT_EN
        ec = (m_errs > 65535) ? 16'hFFFF : 16'(m_errs);
`endif
        s.b   = b;
        s.sig = {dv, fe, m_locked, m_user, m_ch, ec};
        stim.push_back(s);
        m_zeros = b ? 0 : m_zeros + 1;
    endtask

    // Bits the receiver cannot frame (idle line, partial frame while hunting).
    task automatic push_junk(input int n_zero_bits);
        repeat (n_zero_bits) push(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    // Frame-level rules: a tracked frame needs exactly ten sync zeros; an early
    // one drops the frame, an eleventh zero errors but the hunt then resyncs on
    // the same one. A hunted frame is taken if ten or more zeros precede its one.
    task automatic model_frame(input frame_t f);
        int hdr, fe_a, fe_b, dv_at;
        bit decode;
        logic [191:0] flat;
        gen_bits(f);
        hdr   = f.sync_zeros + 1;
        fe_a  = -1;
        fe_b  = -1;
        dv_at = -1;
        if (!m_hunting) begin
            if (f.sync_zeros == 10)     decode = 1'b1;
            else if (f.sync_zeros < 10) begin decode = 1'b0; fe_a = f.sync_zeros; end
            else                        begin decode = 1'b1; fe_a = 10; end
        end else begin
            decode = (m_zeros + f.sync_zeros >= 10);
        end
        if (decode) begin
            if (f.bad_sep >= 0) begin fe_b = hdr + 5 * f.bad_sep + 4; m_hunting = 1'b1; end
            else begin dv_at = fb.size() - 1; m_hunting = 1'b0; end
        end else begin
            m_hunting = 1'b1;
        end
        flat = flatten(f.ch);
        foreach (fb[i]) push(fb[i], i == dv_at, (i == fe_a) || (i == fe_b), f.user, flat);
    endtask

    // NRZI-encode stim onto the line; sample 1 ns after each active edge.
    task automatic run_stream();
        obs.delete();
        foreach (stim[i]) begin
            @(negedge clk);
            adat_bitstream = adat_bitstream ^ stim[i].b;
            @(posedge clk);
            #1;
            obs.push_back(observe());
        end
    endtask

    task automatic assert_reset();
        #1 rst_n = 1'b0;
        model_reset();
    endtask

    task automatic release_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        stim.delete();
        assert_reset();
        #2;
        n_cmp++;
        if (observe() !== '0) begin
            n_bad++;
            $display("FAIL reset_state: got %h want 0", observe());
        end
        release_reset();
        push_junk(24);
        run_stream();
        foreach (stim[i]) begin
            n_cmp++;
            if (obs[i] !== stim[i].sig) begin
                n_bad++;
                $display("FAIL reset_idle bit %0d: got %h want %h", i, obs[i], stim[i].sig);
            end
        end
    endtask

    task automatic test_loopback();
        int prev, a3, a4;
        stim.delete();
        assert_reset();
        release_reset();
        push_junk(16);
        model_frame(spec_frame());
        model_frame(rand_frame());
        model_frame(rand_frame());
        model_frame(spec_frame());
        run_stream();
        foreach (stim[i]) begin
            n_cmp++;
            if (obs[i] !== stim[i].sig) begin
                n_bad++;
                $display("FAIL loopback bit %0d: got %h want %h", i, obs[i], stim[i].sig);
            end
        end
        prev = -1;
        foreach (obs[i]) begin
            if (obs[i][SIGW-1]) begin
                if (prev >= 0) begin
                    n_cmp++;
                    if (i - prev != 256) begin
                        n_bad++;
                        $display("FAIL loopback_period: got %0d want 256", i - prev);
                    end
                end
                prev = i;
            end
        end
        a3 = audio_bus[3];
        a4 = audio_bus[4];
        n_cmp++;
        if (a3 != -8388608) begin n_bad++; $display("FAIL loopback_ch3_sign: got %0d want -8388608", a3); end
        n_cmp++;
        if (a4 != -1) begin n_bad++; $display("FAIL loopback_ch4_sign: got %0d want -1", a4); end
        n_cmp++;
        if (user_bits !== 4'hA || locked !== 1'b1) begin
            n_bad++;
            $display("FAIL loopback_user_lock: got %h/%b want a/1", user_bits, locked);
        end
    endtask

    task automatic test_sep_error();
        frame_t f;
        int n_fe, n_dv;
        stim.delete();
        assert_reset();
        release_reset();
        push_junk(16);
        model_frame(rand_frame());
        f = rand_frame();
        f.bad_sep = 1 + 6 * 3 + 2;
        model_frame(f);
        model_frame(rand_frame());
        model_frame(rand_frame());
        run_stream();
        n_fe = 0;
        n_dv = 0;
        foreach (stim[i]) begin
            n_cmp++;
            if (obs[i] !== stim[i].sig) begin
                n_bad++;
                $display("FAIL sep_error bit %0d: got %h want %h", i, obs[i], stim[i].sig);
            end
            n_fe += int'(obs[i][SIGW-2]);
            n_dv += int'(obs[i][SIGW-1]);
        end
        n_cmp++;
        if (n_fe != 1 || n_dv != 3) begin
            n_bad++;
            $display("FAIL sep_error_pulses: got fe=%0d dv=%0d want fe=1 dv=3", n_fe, n_dv);
        end
    endtask

    task automatic test_sync_error();
        frame_t f;
        int n_fe;
        stim.delete();
        assert_reset();
        release_reset();
        push_junk(16);
        model_frame(rand_frame());
        f = rand_frame(); f.sync_zeros = 9;  model_frame(f);
        model_frame(rand_frame());
        f = rand_frame(); f.sync_zeros = 12; model_frame(f);
        model_frame(rand_frame());
        run_stream();
        n_fe = 0;
        foreach (stim[i]) begin
            n_cmp++;
            if (obs[i] !== stim[i].sig) begin
                n_bad++;
                $display("FAIL sync_error bit %0d: got %h want %h", i, obs[i], stim[i].sig);
            end
            n_fe += int'(obs[i][SIGW-2]);
        end
        n_cmp++;
        if (n_fe != 2) begin n_bad++; $display("FAIL sync_error_pulses: got %0d want 2", n_fe); end
`ifdef ADAT_SYNC_RX_ERR_COUNT_EN
        n_cmp++;
        if (err_count !== 16'd2) begin n_bad++; $display("FAIL sync_err_count: got %0d want 2", err_count); end
`endif
    endtask

    task automatic test_midframe_polarity();
        frame_t f;
        int first_dv;
        stim.delete();
        assert_reset();
        adat_bitstream = ~adat_bitstream;
        release_reset();
        gen_bits(rand_frame());
        for (int i = 100; i < fb.size(); i++) push(fb[i], 1'b0, 1'b0, '0, '0);
        f = rand_frame();
        model_frame(f);
        model_frame(rand_frame());
        run_stream();
        first_dv = -1;
        foreach (stim[i]) begin
            n_cmp++;
            if (obs[i] !== stim[i].sig) begin
                n_bad++;
                $display("FAIL midframe bit %0d: got %h want %h", i, obs[i], stim[i].sig);
            end
            if (first_dv < 0 && obs[i][SIGW-1]) first_dv = i;
        end
        n_cmp++;
        if (first_dv != 156 + 255) begin
            n_bad++;
            $display("FAIL midframe_first_dv: got %0d want %0d", first_dv, 156 + 255);
        end
    endtask

    task automatic test_reset_mid();
        frame_t f2;
        int first_dv;
        stim.delete();
        assert_reset();
        release_reset();
        push_junk(16);
        model_frame(rand_frame());
        model_frame(rand_frame());
        f2 = rand_frame();
        model_frame(f2);
        while (stim.size() > 16 + 512 + 150) void'(stim.pop_back());
        run_stream();
        foreach (stim[i]) begin
            n_cmp++;
            if (obs[i] !== stim[i].sig) begin
                n_bad++;
                $display("FAIL reset_mid_pre bit %0d: got %h want %h", i, obs[i], stim[i].sig);
            end
        end
        stim.delete();
        assert_reset();
        #2;
        n_cmp++;
        if (observe() !== '0) begin
            n_bad++;
            $display("FAIL reset_mid_async: got %h want 0", observe());
        end
        release_reset();
        gen_bits(f2);
        for (int i = 150; i < fb.size(); i++) push(fb[i], 1'b0, 1'b0, '0, '0);
        model_frame(rand_frame());
        model_frame(rand_frame());
        run_stream();
        first_dv = -1;
        foreach (stim[i]) begin
            n_cmp++;
            if (obs[i] !== stim[i].sig) begin
                n_bad++;
                $display("FAIL reset_mid_post bit %0d: got %h want %h", i, obs[i], stim[i].sig);
            end
            if (first_dv < 0 && obs[i][SIGW-1]) first_dv = i;
        end
        n_cmp++;
        if (first_dv < 0 || first_dv >= 512) begin
            n_bad++;
            $display("FAIL reset_mid_relock: got %0d want <512", first_dv);
        end
    endtask

    task automatic test_random_frames();
        frame_t f;
        stim.delete();
        assert_reset();
        release_reset();
        push_junk(16);
        for (int k = 0; k < 10; k++) begin
            f = rand_frame();
            if ($urandom_range(0, 3) == 0) f.sync_zeros = int'($urandom_range(8, 13));
            if ($urandom_range(0, 5) == 0) f.bad_sep = int'($urandom_range(0, 47));
            model_frame(f);
        end
        run_stream();
        foreach (stim[i]) begin
            n_cmp++;
            if (obs[i] !== stim[i].sig) begin
                n_bad++;
                $display("FAIL random bit %0d: got %h want %h", i, obs[i], stim[i].sig);
            end
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_loopback();
        test_sep_error();
        test_sync_error();
        test_midframe_polarity();
        test_reset_mid();
        test_random_frames();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
